// File: rtl/mmio_port_responder.sv
// mmio_port_responder: memory-mapped I/O window on the core data bus.
// Four word registers at BASE_ADDR: OUT (RW), IN (RO, synchronized),
// STATUS (write-1-to-clear), TIMER (down-counter).
// The down-counter is built only when the macro MMIO_TIMER_EN is defined;
// otherwise TIMER reads 0, ignores writes, and STATUS bit1 reads 0.
module mmio_port_responder #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  IN_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 32'h1001_0400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Hit,
  input  logic [IN_WIDTH-1:0]   PortIn,
  output logic [DATA_WIDTH-1:0] PortOut
);

  localparam logic [1:0] OFS_OUT    = 2'd0;
  localparam logic [1:0] OFS_IN     = 2'd1;
  localparam logic [1:0] OFS_STATUS = 2'd2;
  localparam logic [1:0] OFS_TIMER  = 2'd3;

  logic [1:0]          offset;
  logic                wr_out;
  logic                wr_status;
  logic                wr_timer;
  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync2;
  logic [IN_WIDTH-1:0] prev;
  logic                in_chg;
  logic                in_chg_set;
  logic                tmr_exp;
  logic [DATA_WIDTH-1:0] timer_val;
  logic                unused_addr_bits;

  // Word access only: byte-lane bits of the address carry no meaning here.
  assign unused_addr_bits = ^Address[1:0];

  assign Hit        = (Address[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]);
  assign offset     = Address[3:2];
  assign wr_out     = Hit && MemWrite && (offset == OFS_OUT);
  assign wr_status  = Hit && MemWrite && (offset == OFS_STATUS);
  assign wr_timer   = Hit && MemWrite && (offset == OFS_TIMER);
  assign in_chg_set = (sync2 != prev);

  // Output port register, loaded by a store to OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut <= '0;
    end else if (wr_out) begin
      PortOut <= WriteData;
    end
  end

  // Two-flop synchronizer plus a delayed copy for change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Sticky input-change flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_chg <= 1'b0;
    end else if (in_chg_set) begin
      in_chg <= 1'b1;
    end else if (wr_status && WriteData[0]) begin
      in_chg <= 1'b0;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [DATA_WIDTH-1:0] timer;
  logic                  tmr_set;

  // Expiry is the 1->0 decrement only; a load (including a load of 0) never expires.
  assign tmr_set   = !wr_timer && (timer == DATA_WIDTH'(1));
  assign timer_val = timer;

  // Down-counter: software load has priority, otherwise count down and hold at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (wr_timer) begin
      timer <= WriteData;
    end else if (timer != '0) begin
      timer <= timer - DATA_WIDTH'(1);
    end
  end

  // Sticky timer-expired flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_exp <= 1'b0;
    end else if (tmr_set) begin
      tmr_exp <= 1'b1;
    end else if (wr_status && WriteData[1]) begin
      tmr_exp <= 1'b0;
    end
  end
`else
  logic unused_timer_wr;

  assign unused_timer_wr = wr_timer;
  assign timer_val       = '0;
  assign tmr_exp         = 1'b0;
`endif

  // Zero-latency read mux; reads never modify state.
  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      case (offset)
        OFS_OUT:    ReadData = PortOut;
        OFS_IN:     ReadData = DATA_WIDTH'(sync2);
        OFS_STATUS: ReadData = DATA_WIDTH'({tmr_exp, in_chg});
        OFS_TIMER:  ReadData = timer_val;
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: one bus cycle per vector, expected
// outputs pushed to a scoreboard queue at drive time and popped at sample time.
// Timer expectations follow the MMIO_TIMER_EN macro.
module tb_mmio_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  pin;
    logic        rst;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [31:0] exp_po;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        hit;
    logic [31:0] po;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];

`ifdef MMIO_TIMER_EN
  localparam logic [31:0] T3 = 32'd3;
  localparam logic [31:0] T2 = 32'd2;
`else
  localparam logic [31:0] T3 = 32'd0;
  localparam logic [31:0] T2 = 32'd0;
`endif

  mmio_port_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic we, input logic re,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [7:0] pin, input logic rst,
                              input logic [31:0] exp_rd, input logic exp_hit,
                              input logic [31:0] exp_po);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.pin = pin; v.rst = rst; v.exp_rd = exp_rd; v.exp_hit = exp_hit; v.exp_po = exp_po;
    return v;
  endfunction

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 entries required 1");
    end else begin
      e = sb.pop_front();
      checks++;
      if (ReadData !== e.rd) begin
        errors++;
        $display("FAIL %s ReadData got %h required %h", e.name, ReadData, e.rd);
      end
      checks++;
      if (Hit !== e.hit) begin
        errors++;
        $display("FAIL %s Hit got %b required %b", e.name, Hit, e.hit);
      end
      checks++;
      if (PortOut !== e.po) begin
        errors++;
        $display("FAIL %s PortOut got %h required %h", e.name, PortOut, e.po);
      end
    end
  endtask

  // Drive one bus cycle at the falling edge, sample combinational outputs 1ns later;
  // any write in the vector lands at the following rising edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    MemWrite  = v.we;
    MemRead   = v.re;
    Address   = v.addr;
    WriteData = v.wdata;
    PortIn    = v.pin;
    reset     = v.rst;
    e.name = v.name; e.rd = v.exp_rd; e.hit = v.exp_hit; e.po = v.exp_po;
    sb.push_back(e);
    #1;
    check_one();
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    Address = '0; WriteData = '0; PortIn = '0;
    repeat (2) @(posedge clk);

    //           name           we    re    addr           wdata          pin    rst   exp_rd         hit   exp_po
    tbl[0]  = mk("rst_out",     1'b0, 1'b1, 32'h1001_0400, 32'h0,         8'h00, 1'b0, 32'h0,         1'b1, 32'h0);
    tbl[1]  = mk("rst_status",  1'b0, 1'b1, 32'h1001_0408, 32'h0,         8'h00, 1'b0, 32'h0,         1'b1, 32'h0);
    tbl[2]  = mk("rst_timer",   1'b0, 1'b1, 32'h1001_040C, 32'h0,         8'h00, 1'b0, 32'h0,         1'b1, 32'h0);
    tbl[3]  = mk("sw_out",      1'b1, 1'b0, 32'h1001_0400, 32'hDEAD_BEEF, 8'h00, 1'b0, 32'h0,         1'b1, 32'h0);
    tbl[4]  = mk("lw_out",      1'b0, 1'b1, 32'h1001_0400, 32'h0,         8'h00, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    tbl[5]  = mk("miss_sw",     1'b1, 1'b1, 32'h1001_0410, 32'h1234_5678, 8'h00, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF);
    tbl[6]  = mk("miss_below",  1'b0, 1'b1, 32'h1001_03FC, 32'h0,         8'h00, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF);
    tbl[7]  = mk("out_kept",    1'b0, 1'b1, 32'h1001_0400, 32'h0,         8'h00, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    tbl[8]  = mk("rw_same",     1'b1, 1'b1, 32'h1001_0400, 32'h0000_00FF, 8'h00, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    tbl[9]  = mk("lw_bytebits", 1'b0, 1'b1, 32'h1001_0403, 32'h0,         8'h00, 1'b0, 32'h0000_00FF, 1'b1, 32'h0000_00FF);
    tbl[10] = mk("sw_in_ign",   1'b1, 1'b0, 32'h1001_0404, 32'h55,        8'h00, 1'b0, 32'h0,         1'b1, 32'h0000_00FF);
    tbl[11] = mk("lw_in_zero",  1'b0, 1'b1, 32'h1001_0404, 32'h0,         8'h00, 1'b0, 32'h0,         1'b1, 32'h0000_00FF);
    tbl[12] = mk("in_edge0",    1'b0, 1'b1, 32'h1001_0404, 32'h0,         8'hA5, 1'b0, 32'h0,         1'b1, 32'h0000_00FF);
    tbl[13] = mk("stat_edge1",  1'b0, 1'b1, 32'h1001_0408, 32'h0,         8'hA5, 1'b0, 32'h0,         1'b1, 32'h0000_00FF);
    tbl[14] = mk("in_edge2",    1'b0, 1'b1, 32'h1001_0404, 32'h0,         8'hA5, 1'b0, 32'h0000_00A5, 1'b1, 32'h0000_00FF);
    tbl[15] = mk("stat_edge3",  1'b0, 1'b1, 32'h1001_0408, 32'h0,         8'hA5, 1'b0, 32'h1,         1'b1, 32'h0000_00FF);
    tbl[16] = mk("w1c_bit1",    1'b1, 1'b1, 32'h1001_0408, 32'h2,         8'hA5, 1'b0, 32'h1,         1'b1, 32'h0000_00FF);
    tbl[17] = mk("stat_kept",   1'b0, 1'b1, 32'h1001_0408, 32'h0,         8'hA5, 1'b0, 32'h1,         1'b1, 32'h0000_00FF);
    tbl[18] = mk("w1c_bit0",    1'b1, 1'b0, 32'h1001_0408, 32'h1,         8'hA5, 1'b0, 32'h0,         1'b1, 32'h0000_00FF);
    tbl[19] = mk("stat_clr",    1'b0, 1'b1, 32'h1001_0408, 32'h0,         8'hA5, 1'b0, 32'h0,         1'b1, 32'h0000_00FF);

    for (int i = 0; i < 20; i++) step(tbl[i]);

    // Set/clear collision: detection of 0xA5->0x3C lands on the same edge as a W1C of bit0.
    step(mk("col_chg",    1'b0, 1'b1, 32'h1001_0400, 32'h0, 8'h3C, 1'b0, 32'h0000_00FF, 1'b1, 32'h0000_00FF));
    step(mk("col_in_old", 1'b0, 1'b1, 32'h1001_0404, 32'h0, 8'h3C, 1'b0, 32'h0000_00A5, 1'b1, 32'h0000_00FF));
    step(mk("col_w1c",    1'b1, 1'b1, 32'h1001_0408, 32'h1, 8'h3C, 1'b0, 32'h0,         1'b1, 32'h0000_00FF));
    step(mk("col_set_win",1'b0, 1'b1, 32'h1001_0408, 32'h0, 8'h3C, 1'b0, 32'h1,         1'b1, 32'h0000_00FF));
    step(mk("col_clr",    1'b1, 1'b0, 32'h1001_0408, 32'h1, 8'h3C, 1'b0, 32'h0,         1'b1, 32'h0000_00FF));
    step(mk("col_clr_rd", 1'b0, 1'b1, 32'h1001_0408, 32'h0, 8'h3C, 1'b0, 32'h0,         1'b1, 32'h0000_00FF));

`ifdef MMIO_TIMER_EN
    // Countdown 3,2,1,0 with expiry on the edge reaching 0, then hold.
    step(mk("tmr_load3",  1'b1, 1'b1, 32'h1001_040C, 32'd3, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_3",      1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd3, 1'b1, 32'h0000_00FF));
    step(mk("tmr_2",      1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd2, 1'b1, 32'h0000_00FF));
    step(mk("tmr_noexp",  1'b0, 1'b1, 32'h1001_0408, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_0",      1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_exp",    1'b0, 1'b1, 32'h1001_0408, 32'd0, 8'h3C, 1'b0, 32'd2, 1'b1, 32'h0000_00FF));
    step(mk("tmr_hold",   1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_w1c",    1'b1, 1'b0, 32'h1001_0408, 32'd2, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_load0",  1'b1, 1'b0, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_l0_st",  1'b0, 1'b1, 32'h1001_0408, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_load2",  1'b1, 1'b0, 32'h1001_040C, 32'd2, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("tmr_reload", 1'b1, 1'b1, 32'h1001_040C, 32'd7, 8'h3C, 1'b0, 32'd2, 1'b1, 32'h0000_00FF));
    step(mk("tmr_7",      1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd7, 1'b1, 32'h0000_00FF));
`else
    // Without the counter, TIMER ignores writes and reads 0.
    step(mk("ntmr_sw",    1'b1, 1'b1, 32'h1001_040C, 32'd3, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("ntmr_rd1",   1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("ntmr_rd2",   1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("ntmr_stat",  1'b0, 1'b1, 32'h1001_0408, 32'd0, 8'h3C, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
`endif

    // Reset mid-countdown, on the same edge a PortIn change would be detected.
    step(mk("mr_load3",   1'b1, 1'b0, 32'h1001_040C, 32'd3, 8'h81, 1'b0, 32'd0, 1'b1, 32'h0000_00FF));
    step(mk("mr_3",       1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h81, 1'b0, T3,    1'b1, 32'h0000_00FF));
    step(mk("mr_2_rst",   1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h81, 1'b1, T2,    1'b1, 32'h0000_00FF));
    step(mk("mr_status",  1'b0, 1'b1, 32'h1001_0408, 32'd0, 8'h81, 1'b0, 32'd0, 1'b1, 32'h0));
    step(mk("mr_timer",   1'b0, 1'b1, 32'h1001_040C, 32'd0, 8'h81, 1'b0, 32'd0, 1'b1, 32'h0));
    step(mk("mr_in",      1'b0, 1'b1, 32'h1001_0404, 32'd0, 8'h81, 1'b0, 32'h81, 1'b1, 32'h0));

    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
